aes_inv_round_ctrl: RTL and testbench

Iterative AES inverse-cipher engine. It accepts one 128-bit ciphertext block over a valid/ready handshake and sequences one decryption round per clock. Each round uses the existing inv_sub_bytes block plus inline InvShiftRows, AddRoundKey and InvMixColumns logic. Round keys are fetched from an external expanded-key store addressed by this block, and the plaintext is presented on a valid/ready output port. It sits between the key-expansion store and the downstream consumer of decrypted data.

---
 rtl/inv_sub_bytes.sv | 49 ++++
 rtl/aes_inv_round_ctrl.sv | 141 ++++++++++++++
 tb/tb_aes_inv_round_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inv_sub_bytes.sv
// AES InvSubBytes over a full 128-bit state: inverse affine map followed by the
// multiplicative inverse in GF(2^8) (poly 0x11b), computed as x^254 so no ROM is needed.
module inv_sub_bytes (
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = xtime(aa);
    end
    return r;
  endfunction

  // x^254 == x^-1 for x != 0, and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // Byte-parallel inverse S-box.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < 16; i++) begin
      data_o[8*i +: 8] = gf_inv(inv_affine(data_i[8*i +: 8]));
    end
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse cipher: one decryption round per clock, round keys read
// combinationally from an external expanded-key store, valid/ready on both sides.
module aes_inv_round_ctrl #(
  parameter int unsigned NR     = 10,
  parameter int unsigned KEY_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_data,
  output logic [KEY_AW-1:0] key_addr,
  input  logic [127:0]      round_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_data,
  output logic              busy
);

  localparam logic [KEY_AW-1:0] LastKey  = KEY_AW'(NR);
  localparam logic [KEY_AW-1:0] FirstRnd = KEY_AW'(NR - 1);

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  state_e            state_q, state_d;
  logic [127:0]      st_q, st_d;
  logic [KEY_AW-1:0] rnd_q, rnd_d;

  logic [127:0] sr;   // InvShiftRows(st)
  logic [127:0] sb;   // InvSubBytes(sr)
  logic [127:0] ark;  // sb ^ round_key
  logic [127:0] mc;   // InvMixColumns(ark)

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column times the circulant {0e,0b,0d,09}; multiples built from a shared xtime chain.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a, x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      a     = col[31-8*i -: 8];
      x2    = xtime(a);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[i] = x8 ^ a;
      mb[i] = x8 ^ x2 ^ a;
      md[i] = x8 ^ x4 ^ a;
      me[i] = x8 ^ x4 ^ x2;
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

  // Round datapath: byte i sits at [127-8i -: 8], row i%4, column i/4.
  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = st_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end
  end

  inv_sub_bytes u_inv_sub_bytes (
    .data_i (sr),
    .data_o (sb)
  );

  assign ark = sb ^ round_key;

  // Next-state, key index and input handshake.
  always_comb begin
    state_d  = state_q;
    st_d     = st_q;
    rnd_d    = rnd_q;
    in_ready = 1'b0;
    key_addr = LastKey;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          st_d    = in_data ^ round_key;
          rnd_d   = FirstRnd;
          state_d = (NR == 1) ? StFinal : StRound;
        end
      end
      StRound: begin
        key_addr = rnd_q;
        st_d     = mc;
        if (rnd_q == KEY_AW'(1)) begin
          state_d = StFinal;
        end else begin
          rnd_d = rnd_q - KEY_AW'(1);
        end
      end
      StFinal: begin
        key_addr = '0;
        st_d     = ark;
        state_d  = StDone;
      end
      StDone: begin
        key_addr = '0;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Nothing is accepted while reset is asserted.
    if (rst) in_ready = 1'b0;
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_data  = st_q;

  // State registers with synchronous reset taking priority over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      st_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rnd_q   <= rnd_d;
    end
  end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Scoreboard bench for aes_inv_round_ctrl: AES-128 instance plus an AES-256 (NR=14) instance.
module tb_aes_inv_round_ctrl;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ZK_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ZK_PT  = 128'h0;
  localparam logic [127:0] JUNK   = 128'hdeadbeef_0badf00d_12345678_9abcdef0;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // AES-128 instance
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_data, round_key, out_data;
  logic [3:0]   key_addr;
  // AES-256 instance
  logic         b_in_valid, b_in_ready, b_out_valid, b_busy;
  logic [127:0] b_in_data, b_round_key, b_out_data;
  logic [3:0]   b_key_addr;

  aes_inv_round_ctrl #(.NR(10), .KEY_AW(4)) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .key_addr (key_addr), .round_key (round_key), .out_valid (out_valid),
    .out_ready (out_ready), .out_data (out_data), .busy (busy)
  );

  aes_inv_round_ctrl #(.NR(14), .KEY_AW(4)) dut14 (
    .clk (clk), .rst (rst), .in_valid (b_in_valid), .in_ready (b_in_ready),
    .in_data (b_in_data), .key_addr (b_key_addr), .round_key (b_round_key),
    .out_valid (b_out_valid), .out_ready (1'b1), .out_data (b_out_data), .busy (b_busy)
  );

  // Key stores: set 0 = FIPS C.1 key, set 1 = all-zero key; ks14 = FIPS C.3 key.
  logic [127:0] ks10 [2][11];
  logic [127:0] ks14 [15];
  logic         pend_sel = 1'b0, act_sel = 1'b0;
  assign round_key   = ks10[busy ? act_sel : pend_sel][key_addr];
  assign b_round_key = ks14[b_key_addr];
  always @(negedge clk) if (in_valid && in_ready) act_sel <= pend_sel;

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- key expansion (bench side) ----------------
  function automatic logic [7:0] t_xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] t_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00, aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= aa;
      aa = t_xt(aa);
    end
    return r;
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p = x, r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = t_mul(p, p);
      r = t_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  logic [31:0] w [60];
  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = t_xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [127:0] exp_q[$], b_exp_q[$];
  int           acc_q[$], b_acc_q[$];
  logic [127:0] pend_pt, b_pend_pt;
  logic         ov_prev = 1'b0, b_ov_prev = 1'b0;
  int           rise_cyc, b_rise_cyc, last_hs;

  // Input monitors: every accepted block pushes its expected plaintext.
  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      exp_q.push_back(pend_pt);
      acc_q.push_back(cyc);
    end
    if (b_in_valid && b_in_ready) begin
      b_exp_q.push_back(b_pend_pt);
      b_acc_q.push_back(cyc);
    end
  end

  // Output monitors: pop and compare plaintext and acceptance-to-valid latency.
  always @(negedge clk) begin
    logic [127:0] e;
    int a;
    if (out_valid && !ov_prev) rise_cyc = cyc;
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      last_hs = cyc;
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out10_unexpected: got %h with no block outstanding", out_data);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("out10_data", out_data, e);
        chk("out10_latency", 128'(rise_cyc - a), 128'(11));
      end
    end
    if (b_out_valid && !b_ov_prev) b_rise_cyc = cyc;
    b_ov_prev = b_out_valid;
    if (b_out_valid) begin
      if (b_exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL out14_unexpected: got %h with no block outstanding", b_out_data);
      end else begin
        e = b_exp_q.pop_front();
        a = b_acc_q.pop_front();
        chk("out14_data", b_out_data, e);
        chk("out14_latency", 128'(b_rise_cyc - a), 128'(15));
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offers a block and returns after the accepting edge with in_valid still high.
  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input logic sel,
                      output int acc);
    int i;
    in_data = ct; pend_pt = pt; pend_sel = sel; in_valid = 1'b1;
    acc = -1;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (i == 60) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1");
    end else begin
      acc = cyc;
    end
    step();
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && b_exp_q.size() == 0) break;
      step();
    end
    if (i == 200) begin
      n_cmp++; n_err++;
      $display("FAIL %s_timeout: %0d blocks outstanding, required 0", name,
               exp_q.size() + b_exp_q.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int acc1, acc2, i;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; pend_pt = '0; b_pend_pt = '0;
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 10);
    for (int r = 0; r <= 10; r++) ks10[0][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand(256'h0, 4, 10);
    for (int r = 0; r <= 10; r++) ks10[1][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    for (int r = 0; r <= 14; r++) ks14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_key_addr", 128'(key_addr), 128'(10));
    chk("rst_out_data", out_data, 128'h0);
    chk("rst_key_addr14", 128'(b_key_addr), 128'(14));
    chk("rst_in_ready14", 128'(b_in_ready), 128'(0));
    step(); rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 128'(in_ready), 128'(1));
    step();

    // C.1 with key_addr sequence; junk offered while busy must be ignored
    in_data = C1_CT; pend_pt = PT; pend_sel = 1'b0; in_valid = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("key_addr_%0d", k), 128'(key_addr), 128'(10 - k));
      step();
      if (k == 0) begin in_data = JUNK; pend_pt = JUNK; end
      if (k == 10) in_valid = 1'b0;
    end
    drain("c1");

    // Backpressure in DONE
    out_ready = 1'b0;
    send(C1_CT, PT, 1'b0, acc1);
    in_valid = 1'b0;
    for (i = 0; i < 30; i++) begin
      if (out_valid) break;
      step();
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_data", out_data, PT);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
      step();
      in_valid = 1'b1; in_data = JUNK; pend_pt = JUNK;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("bp_release_in_ready", 128'(in_ready), 128'(1));
    chk("bp_release_busy", 128'(busy), 128'(0));
    step();
    drain("bp");

    // Back-to-back: C.1 then zero-key block with in_valid held high
    send(C1_CT, PT, 1'b0, acc1);
    send(ZK_CT, ZK_PT, 1'b1, acc2);
    in_valid = 1'b0;
    chk("b2b_accept_gap", 128'(acc2 - last_hs), 128'(1));
    drain("b2b");

    // Reset during the 5th ROUND cycle discards the block
    send(C1_CT, PT, 1'b0, acc1);
    in_valid = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
    step();
    @(negedge clk);
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_key_addr", 128'(key_addr), 128'(10));
    step();
    rst = 1'b0;
    exp_q.delete(); acc_q.delete();
    send(C1_CT, PT, 1'b0, acc1);
    in_valid = 1'b0;
    drain("post_rst");

    // AES-256 instance, FIPS C.3
    b_in_data = C3_CT; b_pend_pt = PT; b_in_valid = 1'b1;
    for (i = 0; i < 60; i++) begin
      @(negedge clk);
      if (b_in_ready) break;
    end
    if (i == 60) begin
      n_cmp++; n_err++;
      $display("FAIL send14_timeout: in_ready stayed 0, required 1");
    end
    step();
    b_in_valid = 1'b0;
    drain("c3");
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
